// File: rtl/audio_pkg.sv
// Shared definitions for the board audio path.
// Default I2S framing parameters, the stereo sample container type and
// the transmitter state encoding used by i2s_dac_tx.
package audio_pkg;

   localparam int DATA_W_DEF    = 16;   // bits per channel sample
   localparam int SLOT_BITS_DEF = 32;   // BCLK periods per channel slot
   localparam int BCLK_DIV_DEF  = 4;    // refclk cycles per BCLK period

   // refclk cycles in one stereo frame (left slot + right slot)
   localparam int FRAME_CYCLES = 2 * SLOT_BITS_DEF * BCLK_DIV_DEF;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] left;
      logic [DATA_W_DEF-1:0] right;
   } stereo_sample_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } tx_state_e;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S frame timing generator.
// Runs the refclk divider (div_cnt) and the bit counter (bit_cnt) that
// together define one stereo frame, and produces registered BCLK/LRCK plus
// look-ahead timing information for the serializer in the parent.
//
// Ports:
//   clk         in   refclk
//   rst         in   synchronous active-high reset
//   run_i       in   transmitter is in RUN this cycle
//   run_nxt_i   in   transmitter will be in RUN next cycle
//   bclk_o      out  registered bit clock for the current cycle
//   lrck_o      out  registered slot select (0 left, 1 right)
//   load_o      out  this cycle is the last cycle of a frame
//   load_nxt_o  out  next cycle is the last cycle of a frame
//   pos_nxt_o   out  slot position (bit_cnt mod SLOT_BITS) of next cycle
//   chan_nxt_o  out  channel (0 left, 1 right) of next cycle
module i2s_clkgen #(
   parameter int SLOT_BITS = 32,
   parameter int BCLK_DIV  = 4,
   localparam int DIV_W    = $clog2(BCLK_DIV),
   localparam int BIT_W    = $clog2(2 * SLOT_BITS),
   localparam int POS_W    = $clog2(SLOT_BITS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic             run_nxt_i,
   output logic             bclk_o,
   output logic             lrck_o,
   output logic             load_o,
   output logic             load_nxt_o,
   output logic [POS_W-1:0] pos_nxt_o,
   output logic             chan_nxt_o
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
   localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_BITS);

   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [BIT_W-1:0] pos_full_s;
   logic             bclk_q, lrck_q;

   // Next counter values; counters restart from zero whenever RUN is (re)entered
   always_comb begin
      div_d = '0;
      bit_d = '0;
      if (run_i && run_nxt_i) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            if (bit_q == BIT_LAST) begin
               bit_d = '0;
            end else begin
               bit_d = bit_q + BIT_W'(1);
            end
         end else begin
            div_d = div_q + DIV_W'(1);
            bit_d = bit_q;
         end
      end else begin
         div_d = '0;
         bit_d = '0;
      end
   end

   // Decode of the next-cycle counter state for the registered outputs
   always_comb begin
      chan_nxt_o = (bit_d >= SLOT);
      if (chan_nxt_o) begin
         pos_full_s = bit_d - SLOT;
      end else begin
         pos_full_s = bit_d;
      end
      pos_nxt_o  = pos_full_s[POS_W-1:0];
      load_o     = run_i && (div_q == DIV_LAST) && (bit_q == BIT_LAST);
      load_nxt_o = run_nxt_i && (div_d == DIV_LAST) && (bit_d == BIT_LAST);
   end

   // Counter and clock output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         bit_q  <= '0;
         bclk_q <= 1'b0;
         lrck_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         bit_q  <= bit_d;
         bclk_q <= run_nxt_i && (div_d >= DIV_HALF);
         lrck_q <= run_nxt_i && chan_nxt_o;
      end
   end

   assign bclk_o = bclk_q;
   assign lrck_o = lrck_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter for the codec DAC path.
// Accepts stereo PCM pairs over valid/ready into a one-entry holding buffer,
// moves them into the frame register at the end of every frame and shifts
// them out MSB first with the standard one-BCLK I2S delay.
//
// Ports:
//   refclk       in   12 MHz PLL clock, sole clock
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock; low forces IDLE
//   s_valid      in   sample pair valid
//   s_ready      out  holding buffer can accept a pair
//   s_left       in   left sample (two's complement)
//   s_right      in   right sample (two's complement)
//   aud_bclk     out  bit clock to codec
//   aud_daclrck  out  0 = left slot, 1 = right slot
//   aud_dacdat   out  serial data, MSB first
//   underrun     out  one-cycle pulse: frame loaded from an empty buffer
module i2s_dac_tx
   import audio_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SLOT_BITS = SLOT_BITS_DEF,
   parameter int BCLK_DIV  = BCLK_DIV_DEF
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_left,
   input  logic [DATA_W-1:0] s_right,
   output logic              aud_bclk,
   output logic              aud_daclrck,
   output logic              aud_dacdat,
   output logic              underrun
);

   localparam int POS_W = $clog2(SLOT_BITS);

   tx_state_e         state_q;
   logic              run_s, run_nxt_s;
   logic              load_s, load_nxt_s, chan_nxt_s;
   logic [POS_W-1:0]  pos_nxt_s;
   logic              xfer_s;

   logic              full_q, full_d;
   logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
   logic [DATA_W-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;

   logic [DATA_W-1:0] chan_word_s, shifted_s;
   logic              in_range_s, dat_d;
   logic              s_ready_q, underrun_q, dacdat_q;

   // Both states move to RUN exactly when the PLL is locked, so the
   // next-state RUN flag is simply the lock input unless reset is asserted.
   assign run_s     = (state_q == ST_RUN);
   assign run_nxt_s = !rst && pll_locked;
   assign xfer_s    = s_valid && s_ready_q;

   i2s_clkgen #(
      .SLOT_BITS (SLOT_BITS),
      .BCLK_DIV  (BCLK_DIV)
   ) u_clkgen (
      .clk        (refclk),
      .rst        (rst),
      .run_i      (run_s),
      .run_nxt_i  (run_nxt_s),
      .bclk_o     (aud_bclk),
      .lrck_o     (aud_daclrck),
      .load_o     (load_s),
      .load_nxt_o (load_nxt_s),
      .pos_nxt_o  (pos_nxt_s),
      .chan_nxt_o (chan_nxt_s)
   );

   // Holding buffer and frame register next state. A transfer on the load
   // cycle refills the buffer while its old contents move to the frame.
   always_comb begin
      full_d  = full_q;
      buf_l_d = buf_l_q;
      buf_r_d = buf_r_q;
      frm_l_d = frm_l_q;
      frm_r_d = frm_r_q;
      if (load_s) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
      if (xfer_s) begin
         full_d  = 1'b1;
         buf_l_d = s_left;
         buf_r_d = s_right;
      end else begin
         buf_l_d = buf_l_q;
         buf_r_d = buf_r_q;
      end
      // Frame register is zero outside a continuing RUN so every fresh
      // RUN period starts with a silent frame.
      if (run_s && run_nxt_s) begin
         if (load_s && full_q) begin
            frm_l_d = buf_l_q;
            frm_r_d = buf_r_q;
         end else if (load_s) begin
            frm_l_d = '0;
            frm_r_d = '0;
         end else begin
            frm_l_d = frm_l_q;
            frm_r_d = frm_r_q;
         end
      end else begin
         frm_l_d = '0;
         frm_r_d = '0;
      end
   end

   // Serializer: select bit DATA_W-p of the channel word for slot
   // positions 1..DATA_W; position 0 and the padding bits are zero.
   always_comb begin
      if (chan_nxt_s) begin
         chan_word_s = frm_r_d;
      end else begin
         chan_word_s = frm_l_d;
      end
      shifted_s  = chan_word_s << (pos_nxt_s - POS_W'(1));
      in_range_s = (pos_nxt_s != '0) && (pos_nxt_s <= POS_W'(DATA_W));
      dat_d      = run_nxt_s && in_range_s && shifted_s[DATA_W-1];
   end

   // State machine, storage and registered handshake/data outputs
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         full_q     <= 1'b0;
         buf_l_q    <= '0;
         buf_r_q    <= '0;
         frm_l_q    <= '0;
         frm_r_q    <= '0;
         s_ready_q  <= 1'b0;
         underrun_q <= 1'b0;
         dacdat_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: state_q <= pll_locked ? ST_RUN : ST_IDLE;
            ST_RUN:  state_q <= pll_locked ? ST_RUN : ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
         full_q     <= full_d;
         buf_l_q    <= buf_l_d;
         buf_r_q    <= buf_r_d;
         frm_l_q    <= frm_l_d;
         frm_r_q    <= frm_r_d;
         s_ready_q  <= run_nxt_s && (!full_d || load_nxt_s);
         underrun_q <= load_nxt_s && !full_d;
         dacdat_q   <= dat_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign underrun   = underrun_q;
   assign aud_dacdat = dacdat_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: directed scenarios followed by random
// traffic, every cycle compared against a frame-arithmetic reference model.
module tb_i2s_dac_tx;
   import audio_pkg::*;

   localparam int DW = 16;
   localparam int SB = 32;
   localparam int BD = 4;
   localparam int FR = 2 * SB * BD;

   logic          refclk = 1'b0;
   logic          rst, pll_locked, s_valid;
   logic [DW-1:0] s_left, s_right;
   logic          s_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun;

   i2s_dac_tx dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_left      (s_left),
      .s_right     (s_right),
      .aud_bclk    (aud_bclk),
      .aud_daclrck (aud_daclrck),
      .aud_dacdat  (aud_dacdat),
      .underrun    (underrun)
   );

   always #5 refclk = ~refclk;

   // Reference model: cycles since RUN entry plus buffer/frame contents
   bit             m_run  = 1'b0;
   int             m_k    = 0;
   bit             m_full = 1'b0;
   stereo_sample_t m_buf  = '0;
   stereo_sample_t m_frm  = '0;
   bit             last_xfer = 1'b0;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_out(output bit eb, output bit el, output bit ed,
                            output bit er, output bit eu, output bit ld);
      int c, dv, bc, p;
      logic [DW-1:0] w;
      eb = 0; el = 0; ed = 0; er = 0; eu = 0; ld = 0;
      if (m_run) begin
         c  = m_k % FR;
         dv = c % BD;
         bc = c / BD;
         eb = (dv >= BD / 2);
         el = (bc >= SB);
         p  = bc % SB;
         w  = el ? m_frm.right : m_frm.left;
         ed = (p >= 1 && p <= DW) ? w[DW - p] : 1'b0;
         ld = (c == FR - 1);
         er = !m_full || ld;
         eu = ld && !m_full;
      end
   endtask

   task automatic model_edge();
      bit eb, el, ed, er, eu, ld;
      model_out(eb, el, ed, er, eu, ld);
      if (rst) begin
         m_run = 0; m_k = 0; m_full = 0; m_buf = '0; m_frm = '0;
         last_xfer = 0;
      end else begin
         last_xfer = er && s_valid;
         if (ld) begin
            m_frm  = m_full ? m_buf : '0;
            m_full = 0;
         end
         if (last_xfer) begin
            m_buf  = {s_left, s_right};
            m_full = 1;
         end
         if (m_run && pll_locked) begin
            m_k++;
         end else if (pll_locked) begin
            m_run = 1; m_k = 0; m_frm = '0;
         end else begin
            m_run = 0; m_k = 0; m_frm = '0;
         end
      end
   endtask

   // One cycle: compare at the falling edge, advance the model at the rising edge
   task automatic step();
      bit eb, el, ed, er, eu, ld;
      model_out(eb, el, ed, er, eu, ld);
      @(negedge refclk);
      check("bclk",     aud_bclk,    eb);
      check("lrck",     aud_daclrck, el);
      check("dacdat",   aud_dacdat,  ed);
      check("s_ready",  s_ready,     er);
      check("underrun", underrun,    eu);
      @(posedge refclk);
      model_edge();
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
      bit done = 0;
      s_valid = 1; s_left = l; s_right = r;
      for (int i = 0; i < 2 * FR && !done; i++) begin
         step();
         done = last_xfer;
      end
      s_valid = 0;
      check("push_done", done, 1);
   endtask

   task automatic wait_pos(input int t);
      bit hit = 0;
      for (int i = 0; i < 2 * FR && !hit; i++) begin
         if (m_run && (m_k % FR) == t) hit = 1;
         else step();
      end
      check("wait_pos", hit, 1);
   endtask

   int drop = 0;

   initial begin
      rst = 1; pll_locked = 1; s_valid = 0; s_left = '0; s_right = '0;
      @(posedge refclk);
      model_edge();
      #1;
      run(5);
      rst = 0;

      // Silent first frame, then the pushed pair, then an underrun frame
      run(20);
      push(16'hA5F0, 16'h0F0F);
      run(3 * FR);

      // Second pair held valid while the buffer is full
      push(16'h1234, 16'h8765);
      push(16'hCAFE, 16'hBEEF);
      run(3 * FR);

      // PLL drop at cycle 70 with a full buffer
      wait_pos(5);
      push(16'h1357, 16'h2468);
      wait_pos(70);
      pll_locked = 0;
      run(6);
      pll_locked = 1;
      run(3 * FR);

      // Reset pulse mid-frame with a full buffer
      wait_pos(5);
      push(16'h7FFF, 16'h8000);
      wait_pos(100);
      rst = 1;
      step();
      rst = 0;
      run(3 * FR);

      // Random traffic with occasional lock loss and reset
      for (int i = 0; i < 4000; i++) begin
         s_valid = ($urandom_range(0, 2) == 0);
         s_left  = DW'($urandom);
         s_right = DW'($urandom);
         if (drop == 0 && $urandom_range(0, 799) == 0) drop = $urandom_range(1, 20);
         pll_locked = (drop == 0);
         if (drop > 0) drop--;
         rst = ($urandom_range(0, 1999) == 0);
         step();
      end
      rst = 0; s_valid = 0; pll_locked = 1;
      run(FR);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
